fp32_iterative_divider: RTL and testbench

//   IEEE-754 single-precision divider, the inverse companion of the team's FP multiplier: result = A / B.

---
 rtl/fp32_iterative_divider.sv | 154 +++++++++++++++
 tb/tb_fp32_iterative_divider.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_iterative_divider.sv
// IEEE-754 single-precision divider: restoring mantissa division, one quotient bit per clock.
// Define FPDIV_SPECIAL_EN to add zero/inf/NaN handling, exponent saturation and div_by_zero.
module fp32_iterative_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            busy
`ifdef FPDIV_SPECIAL_EN
  ,
  output logic            div_by_zero
`endif
);

  typedef enum logic [1:0] {StIdle, StDiv, StNorm} state_e;

  state_e             state_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [24:0]        rem_q;
  logic [23:0]        dvs_q;
  logic [24:0]        quo_q;
  logic [4:0]         cnt_q;

  logic               sign_in;
  logic               quo_bit;
  logic [24:0]        rem_sub;
  logic [24:0]        rem_next;
  logic signed [9:0]  exp_norm;
  logic [22:0]        frac_norm;
  logic [31:0]        norm_val;

  assign sign_in = A[31] ^ B[31];

  // R < 2D always holds, so the shifted remainder never overflows 25 bits.
  assign quo_bit  = rem_q >= {1'b0, dvs_q};
  assign rem_sub  = rem_q - {1'b0, dvs_q};
  assign rem_next = quo_bit ? {rem_sub[23:0], 1'b0} : {rem_q[23:0], 1'b0};

  assign exp_norm  = quo_q[24] ? exp_q : exp_q - 10'sd1;
  assign frac_norm = quo_q[24] ? quo_q[23:1] : quo_q[22:0];

`ifdef FPDIV_SPECIAL_EN
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        spec_hit, spec_dbz;
  logic [31:0] spec_val;
  logic        spec_q, spec_dbz_q;
  logic [31:0] spec_val_q;

  assign a_zero = A[30:23] == 8'h00;
  assign b_zero = B[30:23] == 8'h00;
  assign a_inf  = A[30:23] == 8'hFF && A[22:0] == 23'h0;
  assign b_inf  = B[30:23] == 8'hFF && B[22:0] == 23'h0;
  assign a_nan  = A[30:23] == 8'hFF && A[22:0] != 23'h0;
  assign b_nan  = B[30:23] == 8'hFF && B[22:0] != 23'h0;

  // inf/0 is an exact infinity, so only finite/0 raises div_by_zero.
  always_comb begin
    spec_hit = 1'b1;
    spec_dbz = 1'b0;
    spec_val = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_val = 32'h7FC0_0000;
    end else if (a_inf) begin
      spec_val = {sign_in, 8'hFF, 23'h0};
    end else if (b_zero) begin
      spec_val = {sign_in, 8'hFF, 23'h0};
      spec_dbz = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_val = {sign_in, 31'h0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  always_comb begin
    norm_val = {sign_q, exp_norm[7:0], frac_norm};
    if (spec_q) begin
      norm_val = spec_val_q;
    end else if (exp_norm > 10'sd254) begin
      norm_val = {sign_q, 8'hFF, 23'h0};
    end else if (exp_norm < 10'sd1) begin
      norm_val = {sign_q, 31'h0};
    end
  end
`else
  // Exponent wraps to 8 bits, mirroring the multiplier's plain formula.
  assign norm_val = {sign_q, exp_norm[7:0], frac_norm};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      result  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
`ifdef FPDIV_SPECIAL_EN
      div_by_zero <= 1'b0;
      spec_q      <= 1'b0;
      spec_dbz_q  <= 1'b0;
      spec_val_q  <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sign_q  <= sign_in;
            exp_q   <= $signed({2'b00, A[30:23]}) - $signed({2'b00, B[30:23]}) + 10'sd127;
            rem_q   <= {2'b01, A[22:0]};
            dvs_q   <= {1'b1, B[22:0]};
            quo_q   <= '0;
            cnt_q   <= 5'd24;
            busy    <= 1'b1;
            state_q <= StDiv;
`ifdef FPDIV_SPECIAL_EN
            spec_q     <= spec_hit;
            spec_dbz_q <= spec_dbz;
            spec_val_q <= spec_val;
`endif
          end
        end
        StDiv: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[23:0], quo_bit};
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_q <= StNorm;
        end
        StNorm: begin
          result  <= norm_val;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
`ifdef FPDIV_SPECIAL_EN
          div_by_zero <= spec_dbz_q;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_iterative_divider.sv
// Self-checking bench for fp32_iterative_divider: directed cases, random operands against an
// arithmetic reference model, back-to-back throughput, ignored starts and mid-operation reset.
module tb_fp32_iterative_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp32_iterative_divider #(
    .XLEN(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .A          (A),
    .B          (B),
    .result     (result),
    .done       (done),
    .busy       (busy)
`ifdef FPDIV_SPECIAL_EN
    ,
    .div_by_zero(div_by_zero)
`endif
  );

`ifndef FPDIV_SPECIAL_EN
  assign div_by_zero = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {div_by_zero, result}; quotient computed as an integer division of scaled mantissas.
  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [63:0] ma, mb, q;
    logic [22:0] frac;
    int          e;
    s  = a[31] ^ b[31];
    ma = {40'd0, 1'b1, a[22:0]};
    mb = {40'd0, 1'b1, b[22:0]};
    q  = (ma << 24) / mb;
    e  = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q >= 64'd16777216) begin
      frac = q[23:1];
    end else begin
      frac = q[22:0];
      e    = e - 1;
    end
`ifdef FPDIV_SPECIAL_EN
    begin
      logic az, bz, ai, bi, an, bn;
      az = a[30:23] == 8'h00;
      bz = b[30:23] == 8'h00;
      ai = a[30:23] == 8'hFF && a[22:0] == 0;
      bi = b[30:23] == 8'hFF && b[22:0] == 0;
      an = a[30:23] == 8'hFF && a[22:0] != 0;
      bn = b[30:23] == 8'hFF && b[22:0] != 0;
      if (an || bn || (az && bz) || (ai && bi)) return {1'b0, 32'h7FC0_0000};
      if (ai) return {1'b0, s, 8'hFF, 23'h0};
      if (bz) return {1'b1, s, 8'hFF, 23'h0};
      if (az || bi) return {1'b0, s, 31'h0};
      if (e > 254) return {1'b0, s, 8'hFF, 23'h0};
      if (e < 1) return {1'b0, s, 31'h0};
    end
`endif
    return {1'b0, s, e[7:0], frac};
  endfunction

  // One isolated operation; operands are scrambled after the start edge to prove latching.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] exp_r;
    int          n;
    exp_r = ref_div(a, b);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, 32'd26);
    check({tag, "_result"}, result, exp_r[31:0]);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
`ifdef FPDIV_SPECIAL_EN
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_r[32]});
`endif
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] a_arr[4];
    logic [31:0] b_arr[4];
    logic [31:0] prev_res;
    logic [32:0] exp_r;
    int          ndone, last, idx;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_result", result, 32'h0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_dbz", {31'd0, div_by_zero}, 32'd0);

    run_op("six_by_two", 32'h40C0_0000, 32'h4000_0000);
    check("six_by_two_const", result, 32'h4040_0000);
    run_op("one_by_three", 32'h3F80_0000, 32'h4040_0000);
    check("one_by_three_const", result, 32'h3EAA_AAAA);
    run_op("one_by_zero", 32'h3F80_0000, 32'h0000_0000);
`ifdef FPDIV_SPECIAL_EN
    check("one_by_zero_const", result, 32'h7F80_0000);
`else
    check("one_by_zero_const", result, 32'h7F00_0000);
`endif

    // -7.5/2.5 with stray starts at cycles 5 and 20 of the operation.
    @(negedge clk);
    A = 32'hC0F0_0000;
    B = 32'h4020_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      start = (c == 5 || c == 20);
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        check("neg_latency", c, 32'd26);
        check("neg_result", result, 32'hC040_0000);
      end
    end
    start = 1'b0;
    check("neg_done_count", ndone, 32'd1);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i < 15) begin
        // Keep half the operands in a comfortable exponent range.
        ra[30:23] = 8'(100 + $urandom_range(0, 50));
        rb[30:23] = 8'(100 + $urandom_range(0, 50));
      end
      run_op("rand", ra, rb);
    end

    // Back-to-back with start held high; new operands presented in each done cycle.
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = $urandom;
      b_arr[i] = $urandom;
      a_arr[i][30:23] = 8'(110 + $urandom_range(0, 30));
      b_arr[i][30:23] = 8'(110 + $urandom_range(0, 30));
    end
    @(negedge clk);
    A = a_arr[0];
    B = b_arr[0];
    start = 1'b1;
    @(posedge clk);
    #1;
    prev_res = result;
    last = 0;
    idx = 0;
    for (int c = 1; c <= 107; c++) begin
      @(posedge clk);
      #1;
      check("b2b_busy", {31'd0, busy}, {31'd0, ~done});
      if (done) begin
        exp_r = ref_div(a_arr[idx], b_arr[idx]);
        check("b2b_result", result, exp_r[31:0]);
        check("b2b_gap", c - last, (idx == 0) ? 32'd26 : 32'd27);
        last = c;
        idx++;
        if (idx < 4) begin
          A = a_arr[idx];
          B = b_arr[idx];
        end else begin
          start = 1'b0;
        end
        prev_res = result;
      end else begin
        check("b2b_hold", result, prev_res);
      end
    end
    start = 1'b0;
    check("b2b_count", idx, 32'd4);

    // Reset in the middle of a 6.0/2.0 operation.
    @(negedge clk);
    A = 32'h40C0_0000;
    B = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_result", result, 32'h0);
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("rst_mid_no_done", ndone, 32'd0);
    check("rst_mid_result_hold", result, 32'h0);
    run_op("after_rst", 32'h40C0_0000, 32'h4000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
